// File: rtl/rice_bus_initiator_pkg.sv
// Shared types and helpers for the rice bus initiator.
package rice_bus_initiator_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH    = 32;

  // One byte enable per data byte.
  function automatic int calc_strobe_width(input int data_width);
    return data_width / 8;
  endfunction

  // A single-beat command as it travels from the core side to the bus.
  typedef struct packed {
    logic                                               write;
    logic [DEFAULT_ADDRESS_WIDTH-1:0]                   address;
    logic [calc_strobe_width(DEFAULT_DATA_WIDTH)-1:0]   strobe;
    logic [DEFAULT_DATA_WIDTH-1:0]                      write_data;
  } rice_bus_command_t;

endpackage

// File: rtl/rice_bus_if.sv
// Rice bus request/response signal bundle.
interface rice_bus_if
  import rice_bus_initiator_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                                       request_valid;
  logic                                       request_ready;
  logic                                       write;
  logic [ADDRESS_WIDTH-1:0]                   address;
  logic [calc_strobe_width(DATA_WIDTH)-1:0]   strobe;
  logic [DATA_WIDTH-1:0]                      write_data;
  logic                                       response_valid;
  logic                                       response_ready;
  logic [DATA_WIDTH-1:0]                      read_data;
  logic                                       error;

  modport master (
    output request_valid, write, address, strobe, write_data, response_ready,
    input  request_ready, response_valid, read_data, error
  );

  modport slave (
    input  request_valid, write, address, strobe, write_data, response_ready,
    output request_ready, response_valid, read_data, error
  );
endinterface

// File: rtl/rice_bus_initiator_tag_fifo.sv
// 1-bit in-order tag FIFO; remembers the command type of each in-flight
// transaction so the response can be labelled.
module rice_bus_initiator_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_data,
  output logic o_head,
  output logic o_full,
  output logic o_empty
);
  // One extra pointer bit separates full from empty.
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [DEPTH-1:0] r_mem;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;
  logic [PW-1:0]    w_fill;

  generate
    if (DEPTH > 1) begin : g_idx
      assign w_wr_idx = r_wr_ptr[IW-1:0];
      assign w_rd_idx = r_rd_ptr[IW-1:0];
    end else begin : g_idx_single
      assign w_wr_idx = '0;
      assign w_rd_idx = '0;
    end
  endgenerate

  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign o_full  = (w_fill == PW'(DEPTH));
  assign o_empty = (w_fill == '0);
  assign o_head  = r_mem[w_rd_idx];

  // Pointer advance; pointers wrap naturally at 2*DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Tag storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_data;
  end
endmodule

// File: rtl/rice_bus_initiator.sv
// Rice bus initiator: registered request stage, in-order outstanding
// tracking, combinational response path, timeout and protocol-error flags.
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are high. A valid, once raised, holds its payload stable until ready;
// valid never depends combinationally on ready of the same channel.
module rice_bus_initiator
  import rice_bus_initiator_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_cmd_valid,
  output logic                                     o_cmd_ready,
  input  logic                                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]                 i_cmd_address,
  input  logic [calc_strobe_width(DATA_WIDTH)-1:0] i_cmd_strobe,
  input  logic [DATA_WIDTH-1:0]                    i_cmd_write_data,
  output logic                                     o_rsp_valid,
  input  logic                                     i_rsp_ready,
  output logic                                     o_rsp_write,
  output logic [DATA_WIDTH-1:0]                    o_rsp_read_data,
  output logic                                     o_rsp_error,
  output logic                                     o_busy,
  output logic                                     o_timeout,
  output logic                                     o_protocol_error,
  rice_bus_if.master                               bus_if
);
  localparam int SW = calc_strobe_width(DATA_WIDTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic                     r_req_valid;
  logic                     r_req_write;
  logic [ADDRESS_WIDTH-1:0] r_req_address;
  logic [SW-1:0]            r_req_strobe;
  logic [DATA_WIDTH-1:0]    r_req_write_data;
  logic [CW-1:0]            r_cnt;
  logic [WW-1:0]            r_wait;
  logic                     r_timeout;
  logic                     r_protocol_error;

  logic          w_cnt_zero;
  logic          w_cmd_hs;
  logic          w_req_hs;
  logic          w_rsp_hs;
  logic          w_pop;
  logic          w_spurious;
  logic [WW-1:0] w_wait_next;
  logic          w_tag_head;
  logic          w_tag_full;
  logic          w_tag_empty;
  logic          w_unused_tag_status;

  // Handshake and response-path decode. A response with nothing
  // outstanding is swallowed (ready forced high) and never shown upstream.
  always_comb begin
    w_cnt_zero  = (r_cnt == '0);
    o_cmd_ready = !i_rst && (r_cnt < CW'(MAX_OUTSTANDING))
                  && (!r_req_valid || bus_if.request_ready);
    w_cmd_hs    = i_cmd_valid && o_cmd_ready;
    w_req_hs    = r_req_valid && !i_rst && bus_if.request_ready;
    w_rsp_hs    = bus_if.response_valid && (w_cnt_zero || i_rsp_ready);
    w_pop       = w_rsp_hs && !w_cnt_zero;
    w_spurious  = w_rsp_hs && w_cnt_zero;
  end

  assign bus_if.request_valid  = r_req_valid && !i_rst;
  assign bus_if.write          = r_req_write;
  assign bus_if.address        = r_req_address;
  assign bus_if.strobe         = r_req_strobe;
  assign bus_if.write_data     = r_req_write_data;
  assign bus_if.response_ready = w_cnt_zero ? 1'b1 : i_rsp_ready;

  assign o_rsp_valid      = !i_rst && !w_cnt_zero && bus_if.response_valid;
  assign o_rsp_write      = w_tag_head;
  assign o_rsp_read_data  = bus_if.read_data;
  assign o_rsp_error      = bus_if.error;
  assign o_busy           = !i_rst && !w_cnt_zero;
  assign o_timeout        = r_timeout;
  assign o_protocol_error = r_protocol_error;

  // FIFO status mirrors r_cnt; it is exposed by the FIFO for standalone use.
  assign w_unused_tag_status = w_tag_full ^ w_tag_empty;

  // Request stage: capture on command accept, drop valid once the bus takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req_valid <= 1'b0;
    end else if (w_cmd_hs) begin
      r_req_valid      <= 1'b1;
      r_req_write      <= i_cmd_write;
      r_req_address    <= i_cmd_address;
      r_req_strobe     <= i_cmd_strobe;
      r_req_write_data <= i_cmd_write_data;
    end else if (w_req_hs) begin
      r_req_valid <= 1'b0;
    end
  end

  // Outstanding count: up on accept, down on a real response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      case ({w_cmd_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Response wait counter: idle or just-answered restarts it, else saturates.
  always_comb begin
    w_wait_next = r_wait;
    if (w_rsp_hs || w_cnt_zero) begin
      w_wait_next = '0;
    end else if (r_wait < WW'(TIMEOUT_CYCLES)) begin
      w_wait_next = r_wait + 1'b1;
    end
  end

  // Wait counter plus the two sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait           <= '0;
      r_timeout        <= 1'b0;
      r_protocol_error <= 1'b0;
    end else begin
      r_wait <= w_wait_next;
      if (w_wait_next == WW'(TIMEOUT_CYCLES)) r_timeout <= 1'b1;
      if (w_spurious) r_protocol_error <= 1'b1;
    end
  end

  rice_bus_initiator_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_cmd_hs),
    .i_pop   (w_pop),
    .i_data  (i_cmd_write),
    .o_head  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );
endmodule

// File: doc/rice_bus_initiator.md
# rice_bus_initiator

Synthesizable initiator (master) end of the rice bus request/response protocol. Accepts single-beat read/write commands on a simple valid/ready command port, drives them onto the bus through a registered request stage, tracks up to `MAX_OUTSTANDING` in-flight transactions in order, and returns each response on a result port tagged with its command type. It sits between core-side agents (fetch, load/store) and any rice bus slave, and serves as the DUT counterpart to the slave BFM in unit benches.

## Interface
- `ADDRESS_WIDTH`, default 32: command and bus address width.
- `DATA_WIDTH`, default 32: data width; strobe width is `DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, default 4: maximum accepted-but-unresponded transactions; must be a power of 2 and at least 1.
- `TIMEOUT_CYCLES`, default 1024: response wait limit before the timeout flag sets.
- `i_clk` input 1: clock. All logic is on the rising edge.
- `i_rst` input 1: synchronous reset, active-high.
- `i_cmd_valid` input 1: command offered.
- `o_cmd_ready` output 1: command accepted when high together with `i_cmd_valid`.
- `i_cmd_write` input 1: 1 means write, 0 means read.
- `i_cmd_address` input `ADDRESS_WIDTH`: target address.
- `i_cmd_strobe` input `DATA_WIDTH/8`: byte enables for writes.
- `i_cmd_write_data` input `DATA_WIDTH`: write data.
- `o_rsp_valid` output 1: response available.
- `i_rsp_ready` input 1: consumer accepts the response.
- `o_rsp_write` output 1: command type of the responded transaction.
- `o_rsp_read_data` output `DATA_WIDTH`: read data, passed through from the bus.
- `o_rsp_error` output 1: bus error, passed through from the bus.
- `o_busy` output 1: high when the outstanding count is nonzero.
- `o_timeout` output 1: sticky; cleared only by reset.
- `o_protocol_error` output 1: sticky; set by a response that arrives with nothing outstanding.
- `bus_if`, `interface.master` of `rice_bus_if`: request_valid, request_ready, write, address, strobe, write_data, response_valid, response_ready, read_data, error.

## Operation
- Outstanding count `cnt` (0..`MAX_OUTSTANDING`):
  - +1 on a command handshake.
  - −1 on a bus response handshake while `cnt > 0`.
  - Net 0 when both handshakes occur in the same cycle.
- `o_cmd_ready = !i_rst && cnt < MAX_OUTSTANDING && (!req_valid_q || bus_if.request_ready)`.
  - There is no same-cycle bypass from a response freeing a slot.
- Request stage:
  - On a command handshake, load write, address, strobe and write_data, and set `req_valid_q`.
  - On a request handshake without a new command, clear `req_valid_q`.
  - `bus_if.request_valid = req_valid_q`.
  - All request fields stay stable while `request_valid && !request_ready`.
  - A read drives strobe and write_data as captured, unmodified.
- Tag FIFO (depth `MAX_OUTSTANDING`, 1 bit wide):
  - Push `i_cmd_write` on each command handshake.
  - Pop on each response handshake while `cnt > 0`.
  - The head drives `o_rsp_write`.
  - Responses are strictly in order.
- Response path (combinational), normal case (`cnt > 0`):
  - `o_rsp_valid = bus_if.response_valid`.
  - `bus_if.response_ready = i_rsp_ready`.
  - Data and error pass through unchanged.
- Response path, spurious response (`cnt == 0`):
  - `o_rsp_valid = 0`.
  - `bus_if.response_ready = 1`; the response is consumed and dropped.
  - `o_protocol_error` sets on the next edge.
- Timeout counter `wait_q`:
  - Cleared on reset, on any response handshake, and whenever `cnt == 0`.
  - Otherwise increments, saturating at `TIMEOUT_CYCLES`.
  - `o_timeout` sets on the edge where `wait_q` reaches `TIMEOUT_CYCLES`.
  - Operation continues after a timeout; the block keeps waiting.

## Timing
- Reset values: `req_valid_q`, `cnt`, FIFO pointers, `wait_q`, `o_timeout` and `o_protocol_error` are all 0.
- During reset: `o_cmd_ready = 0`, `o_rsp_valid = 0`, `bus_if.request_valid = 0`, `o_busy = 0`.
- Reset mid-transaction discards all in-flight state. Responses that arrive after reset for pre-reset requests count as spurious.
- Command-to-request latency is 1 cycle: a handshake at edge N gives `request_valid` high from N+1.
- Back-to-back commands sustain 1 request per cycle while `request_ready` stays high and `cnt < MAX_OUTSTANDING`.
- Response-to-result latency is 0 cycles (combinational). Backpressure from `i_rsp_ready` propagates directly to `response_ready`.
- Full: `cnt == MAX_OUTSTANDING` forces `o_cmd_ready` low until a response handshake completes; ready rises the following cycle.
- FIFO pointers are `$clog2(MAX_OUTSTANDING)+1` bits and wrap naturally. Full and empty are distinguished by the MSB.

## Structure
- Package `rice_bus_initiator_pkg` holds:
  - typedef `rice_bus_command_t` (write, address, strobe, write_data), sized from the package defaults.
  - the function `calc_strobe_width`.
- Sub-module `rice_bus_initiator_tag_fifo` is a parameterized 1-bit synchronous FIFO with push, pop, head, full and empty.
- The count, timeout and request-stage logic live in the top module.

## Test plan
- Single read:
  - Command: read, address 0x1000.
  - Slave: ready immediately, response after 3 cycles with read_data 0xDEADBEEF, error 0.
  - Required: `request_valid` 1 cycle after the command; `o_rsp_valid` with `o_rsp_write = 0`, data 0xDEADBEEF; `o_busy` returns to 0.
- Request hold:
  - Command: write, address 0x20, strobe 0x3, data 0x1234.
  - Slave: `request_ready` low for 5 cycles.
  - Required: request fields stable for all 5 cycles; `o_cmd_ready` low throughout.
- Outstanding limit:
  - 6 back-to-back commands with `MAX_OUTSTANDING = 4`; the slave withholds responses.
  - Required: exactly 4 accepted; `o_cmd_ready` low; after 1 response, one more command is accepted.
- Ordering and tags:
  - Sequence W, R, W, R; the slave responds in order with error set on the 3rd.
  - Required: `o_rsp_write` reads 1, 0, 1, 0; `o_rsp_error` high only on the 3rd.
- Timeout:
  - `TIMEOUT_CYCLES = 16`; a read is issued and never answered.
  - Required: `o_timeout` high at 16 cycles after `cnt` becomes 1 and stays high; a late response is still delivered normally.
- Spurious response and reset:
  - A response with `cnt == 0` → consumed, `o_protocol_error` = 1, `o_rsp_valid` stays 0.
  - `i_rst` asserted with 2 outstanding → all outputs at reset values and `cnt = 0` on the next edge.
